// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU scheduler.
// Holds the op encoding {opp, asn}, the scheduler FSM state type and
// default widths used by alu_scheduler and rr_arb2.
package alu_pkg;

    localparam int unsigned PART_LEN_DEF = 8;
    localparam int unsigned ALU_LAT_DEF  = 1;
    localparam int unsigned CNT_W        = 4;   // holds ALU_LAT-1 for ALU_LAT up to 15
    localparam int unsigned STAT_W       = 16;

    // Op field meanings
    localparam logic OPP_ASN = 1'b1;
    localparam logic OPP_MUL = 1'b0;
    localparam logic ASN_ADD = 1'b0;
    localparam logic ASN_SUB = 1'b1;

    typedef struct packed {
        logic opp;  // 1 = add/sub, 0 = multiply
        logic asn;  // 0 = add, 1 = subtract (forwarded but ignored for multiply)
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_scheduler_rr_arb2.sv
// Two-way round-robin arbiter.
// Ports: clk, rst_n; valid[1:0] request valids; accept strobe (grant taken);
//        grant_c[1:0] one-hot combinational grant.
// The pointer remembers the last granted requester and only moves on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant_c
);

    logic last_q;

    // With both valid, favour the requester that was not granted last
    always_comb begin
        grant_c = 2'b00;
        if (valid == 2'b11) begin
            grant_c = last_q ? 2'b01 : 2'b10;
        end else begin
            grant_c = valid;
        end
    end

    // Reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept && (grant_c != 2'b00)) begin
            last_q <= grant_c[1];
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one add/sub/multiply ALU between two valid/ready requesters.
// Ports: clk, rst_n; req0_*/req1_* request channels (valid, ready, op, a, b);
//        rsp_* response channel (valid, ready, id, res); alu_a/alu_b/alu_ctrl
//        drive the ALU, alu_res is sampled after ALU_LAT cycles; busy = not IDLE.
// Optional: define ALU_SCHED_STATS_EN to add stat_mul_cnt / stat_as_cnt,
//           saturating counts of accepted multiply and add/sub operations.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned PART_LEN = PART_LEN_DEF,
    parameter int unsigned ALU_LAT  = ALU_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [2*PART_LEN-1:0] req0_a,
    input  logic [2*PART_LEN-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [2*PART_LEN-1:0] req1_a,
    input  logic [2*PART_LEN-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [2*PART_LEN-1:0] rsp_res,
    output logic [2*PART_LEN-1:0] alu_a,
    output logic [2*PART_LEN-1:0] alu_b,
    output logic [1:0]            alu_ctrl,
    input  logic [2*PART_LEN-1:0] alu_res,
    output logic                  busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_mul_cnt,
    output logic [STAT_W-1:0]     stat_as_cnt
`endif
);

    localparam int unsigned DW = 2 * PART_LEN;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic [DW-1:0]    alu_a_d, alu_b_d, rsp_res_d;
    logic [1:0]       alu_ctrl_d;
    logic             rsp_valid_d, rsp_id_d, busy_d;
    logic             accept;
    logic [1:0]       grant;
    op_t              sel_op;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid}),
        .accept  (accept),
        .grant_c (grant)
    );

    // Ready is only offered in IDLE, and never while reset is held
    assign req0_ready = rst_n && (state_q == IDLE) && grant[0];
    assign req1_ready = rst_n && (state_q == IDLE) && grant[1];

    assign sel_op = grant[1] ? op_t'(req1_op) : op_t'(req0_op);

    // Next-state and datapath next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        alu_a_d     = alu_a;
        alu_b_d     = alu_b;
        alu_ctrl_d  = alu_ctrl;
        rsp_valid_d = rsp_valid;
        rsp_id_d    = rsp_id;
        rsp_res_d   = rsp_res;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    id_d       = grant[1];
                    alu_a_d    = grant[1] ? req1_a : req0_a;
                    alu_b_d    = grant[1] ? req1_b : req0_b;
                    alu_ctrl_d = sel_op;
                    cnt_d      = CNT_W'(ALU_LAT - 1);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_res_d   = alu_res;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_res   <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_ctrl  <= alu_ctrl_d;
            rsp_valid <= rsp_valid_d;
            rsp_id    <= rsp_id_d;
            rsp_res   <= rsp_res_d;
            busy      <= busy_d;
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Saturating counts of accepted operations split by opp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_mul_cnt <= '0;
            stat_as_cnt  <= '0;
        end else if (accept) begin
            if (sel_op.opp == OPP_MUL) begin
                if (stat_mul_cnt != '1) stat_mul_cnt <= stat_mul_cnt + STAT_W'(1);
            end else begin
                if (stat_as_cnt != '1) stat_as_cnt <= stat_as_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler.
// u_dut runs ALU_LAT=1 against a combinational ALU model; u_dut3 runs
// ALU_LAT=3 against a registered ALU model.
module tb_alu_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_res, alu_a, alu_b, alu_res;
    logic [1:0]  alu_ctrl;

    logic        v3_valid, v3_ready, w3_ready;
    logic [1:0]  v3_op;
    logic [15:0] v3_a, v3_b;
    logic        rsp3_valid, rsp3_id, busy3;
    logic [15:0] rsp3_res, alu3_a, alu3_b, alu3_res;
    logic [1:0]  alu3_ctrl;
    logic        zero1 = 1'b0;
    logic [1:0]  zero2 = 2'b00;
    logic [15:0] zero16 = 16'h0000;
    logic        one1 = 1'b1;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] stat_mul_cnt, stat_as_cnt, stat3_mul_cnt, stat3_as_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] c);
        logic [31:0] p;
        p = a * b;
        if (c[1]) return c[0] ? (a - b) : (a + b);
        return p[15:0];
    endfunction

    assign alu_res = alu_f(alu_a, alu_b, alu_ctrl);

    always_ff @(posedge clk) alu3_res <= alu_f(alu3_a, alu3_b, alu3_ctrl);

    alu_scheduler #(.PART_LEN(8), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_res(alu_res),
        .busy(busy)
`ifdef ALU_SCHED_STATS_EN
        , .stat_mul_cnt(stat_mul_cnt), .stat_as_cnt(stat_as_cnt)
`endif
    );

    alu_scheduler #(.PART_LEN(8), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v3_valid), .req0_ready(v3_ready), .req0_op(v3_op),
        .req0_a(v3_a), .req0_b(v3_b),
        .req1_valid(zero1), .req1_ready(w3_ready), .req1_op(zero2),
        .req1_a(zero16), .req1_b(zero16),
        .rsp_valid(rsp3_valid), .rsp_ready(one1), .rsp_id(rsp3_id), .rsp_res(rsp3_res),
        .alu_a(alu3_a), .alu_b(alu3_b), .alu_ctrl(alu3_ctrl), .alu_res(alu3_res),
        .busy(busy3)
`ifdef ALU_SCHED_STATS_EN
        , .stat_mul_cnt(stat3_mul_cnt), .stat_as_cnt(stat3_as_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready = 1'b1;
        v3_valid = 0; v3_op = 0; v3_a = 0; v3_b = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_alu_ctrl",  32'(alu_ctrl), 0);
        check("rst_alu_a",     32'(alu_a), 0);
        check("rst_rsp_res",   32'(rsp_res), 0);
        rst_n = 1'b1;
        tick();

        // Single multiply 3*5 on requester 0
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'h0003; req0_b = 16'h0005;
        #1;
        check("mul_ready0", 32'(req0_ready), 1);
        check("mul_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 0;
        #1;
        check("mul_ready_exec", 32'(req0_ready), 0);
        check("mul_alu_ctrl",   32'(alu_ctrl), 32'h0);
        check("mul_alu_a",      32'(alu_a), 32'h3);
        check("mul_alu_b",      32'(alu_b), 32'h5);
        check("mul_busy",       32'(busy), 1);
        check("mul_no_rsp_yet", 32'(rsp_valid), 0);
        tick();
        check("mul_rsp_valid", 32'(rsp_valid), 1);
        check("mul_rsp_res",   32'(rsp_res), 32'h000F);
        check("mul_rsp_id",    32'(rsp_id), 0);
        tick();
        check("mul_rsp_drop",  32'(rsp_valid), 0);
        check("mul_res_keep",  32'(rsp_res), 32'h000F);
        check("mul_idle",      32'(busy), 0);

        // Reset mid-operation discards the in-flight request
        req1_valid = 1; req1_op = 2'b10; req1_a = 16'h0005; req1_b = 16'h0006;
        tick();
        req1_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy",      32'(busy), 0);
        check("mrst_alu_a",     32'(alu_a), 0);
        check("mrst_alu_b",     32'(alu_b), 0);
        check("mrst_alu_ctrl",  32'(alu_ctrl), 0);
        check("mrst_rsp_res",   32'(rsp_res), 0);
        check("mrst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mrst_no_rsp", 32'(rsp_valid), 0);
        end

        // Both requesters valid continuously: grants alternate 0,1,0
        req0_valid = 1; req0_op = 2'b10; req0_a = 16'h0010; req0_b = 16'h0001;
        req1_valid = 1; req1_op = 2'b11; req1_a = 16'h0010; req1_b = 16'h0001;
        #1;
        check("arb1_ready0", 32'(req0_ready), 1);
        check("arb1_ready1", 32'(req1_ready), 0);
        tick();
        check("arb_exec_noready", 32'({req1_ready, req0_ready}), 0);
        tick();
        check("arb1_rsp_valid", 32'(rsp_valid), 1);
        check("arb1_rsp_id",    32'(rsp_id), 0);
        check("arb1_rsp_res",   32'(rsp_res), 32'h0011);
        tick();
        check("arb2_ready0", 32'(req0_ready), 0);
        check("arb2_ready1", 32'(req1_ready), 1);
        tick();
        tick();
        check("arb2_rsp_id",  32'(rsp_id), 1);
        check("arb2_rsp_res", 32'(rsp_res), 32'h000F);
        tick();
        check("arb3_ready0", 32'(req0_ready), 1);
        check("arb3_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 0; req1_valid = 0;
        tick();
        check("arb3_rsp_id",  32'(rsp_id), 0);
        check("arb3_rsp_res", 32'(rsp_res), 32'h0011);
        tick();

        // Backpressure: response held 5 cycles while requester 0 waits
        rsp_ready = 0;
        req1_valid = 1; req1_op = 2'b11; req1_a = 16'h0020; req1_b = 16'h0005;
        #1;
        check("bp_ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 0;
        req0_valid = 1; req0_op = 2'b00; req0_a = 16'h0002; req0_b = 16'h0007;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",   32'(rsp_valid), 1);
            check("bp_res",     32'(rsp_res), 32'h001B);
            check("bp_id",      32'(rsp_id), 1);
            check("bp_noready", 32'({req1_ready, req0_ready}), 0);
            if (i < 4) tick();
        end
        rsp_ready = 1;
        tick();
        check("bp_rsp_drop", 32'(rsp_valid), 0);
        check("bp_res_keep", 32'(rsp_res), 32'h001B);
        check("bp_ready0",   32'(req0_ready), 1);
        tick();
        req0_valid = 0;
        tick();
        check("bp2_valid", 32'(rsp_valid), 1);
        check("bp2_res",   32'(rsp_res), 32'h000E);
        check("bp2_id",    32'(rsp_id), 0);
        tick();

        // ALU_LAT=3 instance: wrap-around add, then a second add
        v3_valid = 1; v3_op = 2'b10; v3_a = 16'hFFFF; v3_b = 16'h0001;
        #1;
        check("lat3_ready", 32'(v3_ready), 1);
        tick();
        v3_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("lat3_alu_a",  32'(alu3_a), 32'hFFFF);
            check("lat3_alu_b",  32'(alu3_b), 32'h0001);
            check("lat3_no_rsp", 32'(rsp3_valid), 0);
            tick();
        end
        check("lat3_rsp_valid", 32'(rsp3_valid), 1);
        check("lat3_rsp_res",   32'(rsp3_res), 32'h0000);
        check("lat3_rsp_id",    32'(rsp3_id), 0);
        tick();
        v3_valid = 1; v3_op = 2'b10; v3_a = 16'h1234; v3_b = 16'h0101;
        tick();
        v3_valid = 0;
        repeat (2) tick();
        check("lat3b_no_rsp", 32'(rsp3_valid), 0);
        tick();
        check("lat3b_rsp_valid", 32'(rsp3_valid), 1);
        check("lat3b_rsp_res",   32'(rsp3_res), 32'h1335);
        tick();

`ifdef ALU_SCHED_STATS_EN
        // Since the mid-stream reset: add, sub, add, sub accepted; one multiply
        check("stat_mul", 32'(stat_mul_cnt), 1);
        check("stat_as",  32'(stat_as_cnt), 4);
        check("stat3_as", 32'(stat3_as_cnt), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_scheduler.md
Name: alu_scheduler

Overview:
- Shares one 2*PART_LEN-bit add/sub/multiply ALU between two requesters.
- Requesters use a valid/ready handshake. Arbitration is round-robin.
- The block registers the winning request's operands, drives the ALU operands and control_sig, waits ALU_LAT cycles, then returns the result tagged with the requester id on a valid/ready response port.
- Sits between the instruction/sequencing layer and the ALU instance.

Parameters:
- PART_LEN, 8, half-word width; all data paths are 2*PART_LEN bits.
- ALU_LAT, 1, cycles from operand launch to alu_res sampling; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_op  input  2  {opp, asn} for requester 0.
- req0_a  input  2*PART_LEN  operand a, requester 0.
- req0_b  input  2*PART_LEN  operand b, requester 0.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same directions and widths as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_id  output  1  requester that owns the result.
- rsp_res  output  2*PART_LEN  result.
- alu_a  output  2*PART_LEN  ALU operand a.
- alu_b  output  2*PART_LEN  ALU operand b.
- alu_ctrl  output  2  ALU control_sig.
- alu_res  input  2*PART_LEN  ALU result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Op encoding (shared package):
  - bit1 opp: 1 = add/sub, 0 = multiply.
  - bit0 asn: 0 = add, 1 = subtract. asn is ignored for multiply but still forwarded.
- Reset values:
  - req*_ready, rsp_valid, rsp_id, busy = 0.
  - rsp_res, alu_a, alu_b = 0; alu_ctrl = 2'b00.
  - FSM = IDLE; latency counter = 0; round-robin pointer = last-granted 1, so requester 0 wins first.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req*_valid, the arbiter grants one requester.
  - reqN_ready is combinational: high only in IDLE for the granted N, for exactly one cycle.
  - On the handshake, capture a, b, op and id into alu_a, alu_b, alu_ctrl and an id register.
  - Load counter = ALU_LAT-1, update the pointer, go to EXEC.
  - ready is never asserted outside IDLE.
- EXEC:
  - alu_a, alu_b and alu_ctrl are held stable.
  - If counter != 0, decrement.
  - If counter == 0, sample alu_res into rsp_res, set rsp_id, assert rsp_valid, go to RESP.
- RESP:
  - rsp_valid, rsp_res and rsp_id are held until rsp_ready.
  - On rsp_valid & rsp_ready: deassert rsp_valid next cycle and return to IDLE.
  - rsp_res keeps its last value after the handshake.
- Latency: acceptance edge to rsp_valid high is ALU_LAT+1 cycles with ALU_LAT=1 counting as the EXEC cycle. Minimum issue interval is ALU_LAT+2 cycles.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last.
  - The pointer updates only on an accepted grant.
- Requesters must hold valid and payload until ready. The block never drops or reorders an accepted request.
- Arithmetic is the ALU's own: results are 2*PART_LEN bits and wrap; the block does no width conversion.
- rst_n asserted in any state: immediate return to reset values. An in-flight operation is discarded and no response is produced.
- rsp_ready while rsp_valid is low has no effect.

Optional Feature:
- ALU_SCHED_STATS_EN defined:
  - Adds outputs stat_mul_cnt[15:0] and stat_as_cnt[15:0].
  - Each counts accepted operations by opp. Counters saturate at 16'hFFFF and reset to 0.
- ALU_SCHED_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - op typedef {opp, asn}.
  - OPP_ASN=1, OPP_MUL=0, ASN_ADD=0, ASN_SUB=1.
  - FSM state typedef.
  - PART_LEN default.
- Sub-module rr_arb2: 2-way round-robin arbiter with valids, accept strobe, grant and pointer register.

Test Plan:
- Reset check: rst_n low mid-stream -> all outputs take their reset values immediately; no rsp_valid after release.
- Single mul: req0 op=2'b00, a=16'h0003, b=16'h0005, ALU_LAT=1 -> req0_ready one cycle; alu_ctrl=00; rsp_valid 2 cycles later with rsp_res=16'h000F, rsp_id=0.
- Arbitration: req0 and req1 both valid continuously, ops add 16'h0010+16'h0001 and sub 16'h0010-16'h0001 -> grants alternate 0,1,0; results 16'h0011 (id0) and 16'h000F (id1).
- Backpressure: hold rsp_ready low 5 cycles -> rsp_valid, rsp_res and rsp_id stable; no req*_ready during the stall.
- Latency param: ALU_LAT=3 with a registered ALU model, add 16'hFFFF+16'h0001 -> rsp_res=16'h0000 (wrap), 4 cycles after accept; alu_a/alu_b stable throughout EXEC.
- Stats (macro on): 3 mul + 2 add/sub accepted -> stat_mul_cnt=3, stat_as_cnt=2.
